l5_latch_bus_master: RTL
========================

# l5_latch_bus_master

Bus initiator for a bank of 8-bit chip-selected storage latches (per-device cs/oe/we strobes, 8-bit write data in, tri-state 8-bit data out). Takes single read/write requests from an upstream valid/ready port and sequences the latch strobes: write setup, write strobe, output-enable wait, sample, turnaround. Returns read data or a write acknowledgement on a one-cycle response pulse. Sits between the datapath/control logic and the latch array. It is the only driver of the latches' cs/oe/we/di.

## Interface
- NDEV, 4: number of latch devices, 1..16
- AW, 2: request address width, ≥ clog2(NDEV)
- RD_WAIT, 1: cycles oe is held before the sample cycle, 1..15
- TURN, 1: idle bus cycles after a read before the next request is accepted, 0..3

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  device index
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  8  read data, held until next read response
- rsp_err  out  1  address ≥ NDEV, valid with rsp_valid
- cs  out  NDEV  one-hot chip selects
- oe  out  1  shared output enable
- we  out  1  shared write enable
- bus_wdata  out  8  to latch data inputs
- bus_rdata  in  8  from the shared latch output bus; Z when no device is enabled
- busy  out  1  state ≠ IDLE

## Operation
- All outputs are registered. States: IDLE, WSETUP, WSTROBE, RENABLE, RSAMPLE, TURN, RESP.
- IDLE: req_ready=1. A handshake (req_valid & req_ready at a rising edge) latches we/addr/wdata.
  - Write → WSETUP.
  - Read → RENABLE.
  - addr ≥ NDEV → RESP with rsp_err=1, rsp_rdata=8'hFF. No strobe is asserted.
- WSETUP, 1 cycle: cs[addr]=1, bus_wdata=wdata, we=0 → WSTROBE.
- WSTROBE, 1 cycle: cs[addr]=1, we=1, bus_wdata held. The latch captures at the closing edge → RESP.
- RENABLE, RD_WAIT cycles (down-counter): cs[addr]=1, oe=1 → RSAMPLE.
- RSAMPLE, 1 cycle: cs[addr]=1, oe=1. bus_rdata is registered into rsp_rdata at the closing edge.
  - Next state is TURN if TURN>0, else RESP.
- TURN, TURN cycles: cs=0, oe=0.
  - rsp_valid=1 in the first TURN cycle only.
  - Then IDLE.
- RESP, 1 cycle: rsp_valid=1, strobes low → IDLE.
  - Used for writes, errors and TURN=0 reads.
- Invariants:
  - we & oe never both high.
  - cs is one-hot or zero.
  - we/oe are high only while some cs bit is high.
  - bus_wdata = 0 outside WSETUP/WSTROBE.
  - oe is always low for ≥1 cycle between reads. The latch output refreshes only on cs/oe change, so this guarantees a fresh read.
- Write responses do not modify rsp_rdata. rsp_err=0 for valid addresses.

## Timing
- Cycle 0 is the handshake cycle.
- Write to a valid address:
  - cs cycles 1–2, we cycle 2.
  - rsp_valid cycle 3.
  - req_ready cycle 4 (IDLE).
  - Throughput is one write per 4 cycles.
- Read:
  - cs/oe cycles 1..RD_WAIT+1.
  - rsp_valid and rsp_rdata valid in cycle RD_WAIT+2.
  - req_ready returns in cycle RD_WAIT+2+TURN when TURN>0, or RD_WAIT+3 when TURN=0.
- Error: rsp_valid in cycle 1, req_ready in cycle 2.
- Reset values: state IDLE; cs=0, oe=0, we=0, bus_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. req_ready=0 while rst is high.
- Reset mid-transaction:
  - All strobes are low in the cycle after the reset edge.
  - The in-flight request is dropped with no rsp_valid.
  - A partial write that never reached the WSTROBE closing edge leaves the latch unchanged.
- req_valid while busy is ignored. Upstream holds it until req_ready.

## Test plan
- NDEV=4, RD_WAIT=1, TURN=1: write 8'hA5 to addr 2 → cs=4'b0100 cycles 1–2, we only cycle 2, rsp_valid cycle 3. Then read addr 2 → oe cycles 1–2, rsp_rdata=8'hA5 in cycle 3, req_ready cycle 4.
- Isolation: write 8'h3C to dev 0 and 8'hC3 to dev 1, then read 1 and 0 → 8'hC3, then 8'h3C. No other cs bit ever asserts.
- RD_WAIT=3, TURN=0: read → oe high for exactly 4 cycles, rsp_valid in cycle 5, req_ready cycle 6. Bus checker passes (no we&oe, cs one-hot, bus_wdata 0 outside writes).
- NDEV=3, AW=2: read addr 3 → cs stays 0, rsp_valid cycle 1 with rsp_err=1 and rsp_rdata=8'hFF.
- rst pulsed in cycle 2 of a read → cs/oe low the next cycle, no rsp_valid, all outputs at reset values. A subsequent read returns the previously written data.
- req_valid held high continuously with alternating we → each request accepted only in IDLE. Response count equals request count, in order.

Source files
------------

// File: rtl/l5_latch_bus_master.sv
// Bus initiator for a bank of chip-selected 8-bit storage latches.
// Sequences cs/we/oe strobes for single read/write requests; all outputs registered.
module l5_latch_bus_master #(
   parameter int unsigned NDEV    = 4,
   parameter int unsigned AW      = 2,
   parameter int unsigned RD_WAIT = 1,
   parameter int unsigned TURN    = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [AW-1:0]   req_addr,
   input  logic [7:0]      req_wdata,
   output logic            rsp_valid,
   output logic [7:0]      rsp_rdata,
   output logic            rsp_err,
   output logic [NDEV-1:0] cs,
   output logic            oe,
   output logic            we,
   output logic [7:0]      bus_wdata,
   input  logic [7:0]      bus_rdata,
   output logic            busy
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WSETUP  = 3'd1;
   localparam logic [2:0] S_WSTROBE = 3'd2;
   localparam logic [2:0] S_RENABLE = 3'd3;
   localparam logic [2:0] S_RSAMPLE = 3'd4;
   localparam logic [2:0] S_TURN    = 3'd5;
   localparam logic [2:0] S_RESP    = 3'd6;

   logic [2:0]      state, nstate;
   logic [3:0]      cnt, ncnt;
   logic [AW-1:0]   addr_q, n_addr;
   logic [7:0]      wdata_q, n_wdata;
   logic            err_q, n_err;
   logic            hs;
   logic            n_strobe;
   logic [NDEV-1:0] n_cs;

   assign hs = req_valid & req_ready;

   always_comb begin
      nstate  = state;
      ncnt    = cnt;
      n_addr  = addr_q;
      n_wdata = wdata_q;
      n_err   = err_q;
      case (state)
         S_IDLE: begin
            if (hs) begin
               n_addr  = req_addr;
               n_wdata = req_wdata;
               n_err   = (32'(req_addr) >= NDEV);
               if (n_err) begin
                  nstate = S_RESP;
               end else if (req_we) begin
                  nstate = S_WSETUP;
               end else begin
                  nstate = S_RENABLE;
                  ncnt   = 4'(RD_WAIT - 1);
               end
            end
         end
         S_WSETUP:  nstate = S_WSTROBE;
         S_WSTROBE: nstate = S_RESP;
         S_RENABLE: begin
            if (cnt == '0) nstate = S_RSAMPLE;
            else           ncnt   = cnt - 4'd1;
         end
         S_RSAMPLE: begin
            if (TURN > 0) begin
               nstate = S_TURN;
               ncnt   = 4'(TURN - 1);
            end else begin
               nstate = S_RESP;
            end
         end
         S_TURN: begin
            if (cnt == '0) nstate = S_IDLE;
            else           ncnt   = cnt - 4'd1;
         end
         S_RESP:  nstate = S_IDLE;
         default: nstate = S_IDLE;
      endcase
   end

   // Strobes are decoded from the next state so they appear with it, not a cycle late.
   always_comb begin
      n_strobe = (nstate == S_WSETUP) || (nstate == S_WSTROBE) ||
                 (nstate == S_RENABLE) || (nstate == S_RSAMPLE);
      n_cs = '0;
      for (int unsigned i = 0; i < NDEV; i++) begin
         n_cs[i] = n_strobe && (32'(n_addr) == i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         cs        <= '0;
         oe        <= 1'b0;
         we        <= 1'b0;
         bus_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         req_ready <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= nstate;
         cnt       <= ncnt;
         addr_q    <= n_addr;
         wdata_q   <= n_wdata;
         err_q     <= n_err;
         cs        <= n_cs;
         we        <= (nstate == S_WSTROBE);
         oe        <= (nstate == S_RENABLE) || (nstate == S_RSAMPLE);
         bus_wdata <= ((nstate == S_WSETUP) || (nstate == S_WSTROBE)) ? n_wdata : '0;
         rsp_valid <= (nstate == S_RESP) || ((state == S_RSAMPLE) && (nstate == S_TURN));
         rsp_err   <= (nstate == S_RESP) && n_err;
         if (state == S_RSAMPLE)
            rsp_rdata <= bus_rdata;
         else if ((nstate == S_RESP) && n_err)
            rsp_rdata <= 8'hFF;
         req_ready <= (nstate == S_IDLE);
         busy      <= (nstate != S_IDLE);
      end
   end

endmodule
